// File: rtl/fifo_pkg.sv
// Shared defaults and state encoding for the fifo / RAM streaming blocks.
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 13;
   localparam int unsigned DEF_RAM_DEPTH  = 5000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/dual_port_ram.sv
// Simple RAM: synchronous write port, combinational read port.
module DualPortRam
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_oe,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata_c
);

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we && (32'(i_waddr) < RAM_DEPTH)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Out-of-range or disabled reads return zero.
   always_comb begin
      o_rdata_c = '0;
      if (i_oe && (32'(i_raddr) < RAM_DEPTH)) begin
         o_rdata_c = r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a frame of consecutive RAM words (wrapping at RAM_DEPTH) and emits
// them as a registered valid/ready stream with a last marker.
module ram_stream_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_length,
   input  logic                  i_abort,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic                  o_ram_oe,
   input  logic [DATA_WIDTH-1:0] i_ram_data,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic                  o_m_last,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [ADDR_WIDTH-1:0] r_remaining;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_m_valid;
   logic                  r_m_last;
   logic                  r_busy;
   logic                  r_ram_oe;
   logic                  r_done;

   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
   logic [ADDR_WIDTH-1:0] w_remaining_nxt;
   logic [DATA_WIDTH-1:0] w_m_data_nxt;
   logic                  w_m_valid_nxt;
   logic                  w_m_last_nxt;
   logic                  w_base_ok;
   logic                  w_accept;
   logic                  w_load;

   assign w_base_ok = (32'(i_base_addr) < RAM_DEPTH);
   assign w_accept  = r_m_valid && i_m_ready;
   assign w_load    = (!r_m_valid || i_m_ready) && (r_remaining != '0);

   // Next-state and datapath update; abort always beats a pending load.
   always_comb begin
      w_state_nxt     = r_state;
      w_rd_addr_nxt   = r_rd_addr;
      w_remaining_nxt = r_remaining;
      w_m_data_nxt    = r_m_data;
      w_m_valid_nxt   = r_m_valid;
      w_m_last_nxt    = r_m_last;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if ((i_length != '0) && w_base_ok) begin
                  w_state_nxt     = S_STREAM;
                  w_rd_addr_nxt   = i_base_addr;
                  w_remaining_nxt = i_length;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_STREAM: begin
            if (i_abort) begin
               w_state_nxt   = S_DONE;
               w_m_valid_nxt = 1'b0;
               w_m_last_nxt  = 1'b0;
            end else begin
               if (w_accept) begin
                  w_m_valid_nxt = 1'b0;
               end
               if (w_load) begin
                  w_m_data_nxt    = i_ram_data;
                  w_m_valid_nxt   = 1'b1;
                  w_m_last_nxt    = (r_remaining == ONE);
                  w_rd_addr_nxt   = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ONE;
                  w_remaining_nxt = r_remaining - ONE;
                  if (r_remaining == ONE) begin
                     w_state_nxt = S_DRAIN;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (i_abort || w_accept) begin
               w_state_nxt   = S_DONE;
               w_m_valid_nxt = 1'b0;
               w_m_last_nxt  = 1'b0;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Status flags are registered from the next state so they track r_state exactly.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rd_addr   <= '0;
         r_remaining <= '0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_busy      <= 1'b0;
         r_ram_oe    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_remaining <= w_remaining_nxt;
         r_m_data    <= w_m_data_nxt;
         r_m_valid   <= w_m_valid_nxt;
         r_m_last    <= w_m_last_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_ram_oe    <= (w_state_nxt == S_STREAM);
         r_done      <= (w_state_nxt == S_DONE);
      end
   end

   assign o_ram_addr = r_rd_addr;
   assign o_ram_oe   = r_ram_oe;
   assign o_m_data   = r_m_data;
   assign o_m_valid  = r_m_valid;
   assign o_m_last   = r_m_last;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a frame-level model predicts every beat,
// directed cases pin latency/boundaries, random frames stress handshake/abort.
module tb_ram_stream_reader;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 13;
   localparam int unsigned DEPTH = 5000;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          i_clk;
   logic          i_rst;
   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [AW-1:0] i_length;
   logic          i_abort;
   logic [AW-1:0] o_ram_addr;
   logic          o_ram_oe;
   logic [DW-1:0] w_ram_data;
   logic [DW-1:0] o_m_data;
   logic          o_m_valid;
   logic          i_m_ready;
   logic          o_m_last;
   logic          o_busy;
   logic          o_done;
   logic          r_we;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;

   beat_t         exp_q[$];
   logic [DW-1:0] got_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            start_cyc = 0;
   int            first_valid_cyc = -1;
   int            done_cyc = -1;
   int            done_cnt = 0;

   ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_length(i_length), .i_abort(i_abort), .o_ram_addr(o_ram_addr),
      .o_ram_oe(o_ram_oe), .i_ram_data(w_ram_data), .o_m_data(o_m_data),
      .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_last(o_m_last),
      .o_busy(o_busy), .o_done(o_done)
   );

   DualPortRam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) ram (
      .i_clk(i_clk), .i_we(r_we), .i_waddr(r_waddr), .i_wdata(r_wdata),
      .i_oe(o_ram_oe), .i_raddr(o_ram_addr), .o_rdata_c(w_ram_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a frame is the word sequence mem[a] = a[7:0] for a = base, base+1, ... mod DEPTH.
   task automatic model_frame(input int base, input int len);
      int a;
      a = base;
      if (len != 0 && base < int'(DEPTH)) begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_back('{data: 8'(a), last: (i == len - 1)});
            a = (a + 1) % int'(DEPTH);
         end
      end
   endtask

   // Single compare process: every visible beat must match the model's next word.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_m_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(o_m_data), 32'hFFFF_FFFF);
            end else begin
               chk("m_data", 32'(o_m_data), 32'(exp_q[0].data));
               chk("m_last", 32'(o_m_last), 32'(exp_q[0].last));
               if (i_m_ready) begin
                  void'(exp_q.pop_front());
                  got_q.push_back(o_m_data);
               end
            end
         end
         chk("last_without_valid", 32'(o_m_last && !o_m_valid), 0);
         chk("oe_without_busy", 32'(o_ram_oe && !o_busy), 0);
         if (o_done) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_cnt++;
         end
      end
   end

   task automatic clear_obs();
      got_q.delete();
      first_valid_cyc = -1;
      done_cyc        = -1;
   endtask

   // Issues a one-cycle start; returns one cycle later, just after the sampling edge.
   task automatic start_frame(input int base, input int len);
      @(posedge i_clk); #1;
      start_cyc   = cyc;
      i_start     = 1'b1;
      i_base_addr = AW'(base);
      i_length    = AW'(len);
      model_frame(base, len);
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int k;
      k = 0;
      while (o_busy && k < limit) begin
         @(posedge i_clk); #1;
         k++;
      end
      chk({name, "_idle"}, 32'(o_busy), 0);
      chk({name, "_model_drained"}, 32'(exp_q.size()), 0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_m_valid"}, 32'(o_m_valid), 0);
      chk({name, "_m_last"}, 32'(o_m_last), 0);
      chk({name, "_done"}, 32'(o_done), 0);
      chk({name, "_busy"}, 32'(o_busy), 0);
      chk({name, "_ram_oe"}, 32'(o_ram_oe), 0);
      chk({name, "_m_data"}, 32'(o_m_data), 0);
      chk({name, "_ram_addr"}, 32'(o_ram_addr), 0);
   endtask

   task automatic random_frame(input int base, input int len, input bit do_abort);
      int k;
      int ab_at;
      ab_at = $urandom_range(0, len + 3);
      start_frame(base, len);
      k = 0;
      while (o_busy && k < 200) begin
         i_m_ready = 1'($urandom_range(0, 1));
         if (do_abort && k == ab_at) i_abort = 1'b1;
         @(posedge i_clk); #1;
         if (i_abort) begin
            i_abort = 1'b0;
            exp_q.delete();
         end
         k++;
      end
      chk("rand_idle", 32'(o_busy), 0);
      chk("rand_model_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int k;
      int dc;
      i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_length = '0;
      i_abort = 1'b0; i_m_ready = 1'b0; r_we = 1'b0; r_waddr = '0; r_wdata = '0;

      // Preload mem[a] = a[7:0] through the write port while held in reset.
      @(posedge i_clk); #1;
      for (int a = 0; a < int'(DEPTH); a++) begin
         r_we = 1'b1; r_waddr = AW'(a); r_wdata = 8'(a);
         @(posedge i_clk); #1;
      end
      r_we = 1'b0;
      check_reset_outputs("reset");
      i_rst = 1'b0;

      // Basic frame, m_ready high: latency 2, done one cycle after the last beat.
      i_m_ready = 1'b1;
      clear_obs();
      start_frame(10, 4);
      wait_idle("basic", 50);
      chk("basic_count", 32'(got_q.size()), 4);
      chk("basic_b0", 32'(got_q[0]), 32'h0A);
      chk("basic_b3", 32'(got_q[3]), 32'h0D);
      chk("basic_latency", 32'(first_valid_cyc - start_cyc), 2);
      chk("basic_done_at", 32'(done_cyc - start_cyc), 6);

      // Address wrap at the top of the RAM.
      clear_obs();
      start_frame(4998, 4);
      wait_idle("wrap", 50);
      chk("wrap_count", 32'(got_q.size()), 4);
      chk("wrap_b0", 32'(got_q[0]), 32'h86);
      chk("wrap_b1", 32'(got_q[1]), 32'h87);
      chk("wrap_b2", 32'(got_q[2]), 32'h00);
      chk("wrap_b3", 32'(got_q[3]), 32'h01);

      // Backpressure: first beat must hold stable for 5 stalled cycles.
      i_m_ready = 1'b0;
      clear_obs();
      start_frame(20, 3);
      k = 0;
      while (!o_m_valid && k < 10) begin
         @(posedge i_clk); #1;
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(o_m_valid), 1);
         chk("stall_data", 32'(o_m_data), 32'h14);
         @(posedge i_clk); #1;
      end
      i_m_ready = 1'b1;
      wait_idle("stall", 50);
      chk("stall_count", 32'(got_q.size()), 3);
      chk("stall_b1", 32'(got_q[1]), 32'h15);
      chk("stall_b2", 32'(got_q[2]), 32'h16);

      // Empty and rejected frames: no beats, done one cycle after start.
      clear_obs();
      start_frame(50, 0);
      wait_idle("empty", 10);
      chk("empty_done_at", 32'(done_cyc - start_cyc), 1);
      chk("empty_no_beat", 32'(first_valid_cyc), 32'hFFFF_FFFF);
      clear_obs();
      start_frame(5000, 4);
      wait_idle("reject", 10);
      chk("reject_done_at", 32'(done_cyc - start_cyc), 1);
      chk("reject_no_beat", 32'(first_valid_cyc), 32'hFFFF_FFFF);

      // start held through STREAM, DRAIN and DONE must be ignored.
      clear_obs();
      dc = done_cnt;
      start_frame(30, 6);
      i_start = 1'b1; i_base_addr = AW'(200); i_length = AW'(2);
      repeat (8) begin
         @(posedge i_clk); #1;
      end
      i_start = 1'b0;
      chk("busy_start_idle", 32'(o_busy), 0);
      wait_idle("busy_start", 20);
      chk("busy_start_count", 32'(got_q.size()), 6);
      chk("busy_start_done_pulses", 32'(done_cnt - dc), 1);

      // Abort after the third accepted beat.
      clear_obs();
      start_frame(100, 50);
      k = 0;
      while (got_q.size() < 3 && k < 20) begin
         @(posedge i_clk); #1;
         k++;
      end
      i_abort = 1'b1; i_m_ready = 1'b0;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      exp_q.delete();
      chk("abort_valid", 32'(o_m_valid), 0);
      chk("abort_last", 32'(o_m_last), 0);
      chk("abort_done", 32'(o_done), 1);
      i_m_ready = 1'b1;
      wait_idle("abort", 10);
      chk("abort_count", 32'(got_q.size()), 3);

      // Reset in the middle of a frame.
      start_frame(100, 50);
      repeat (6) begin
         @(posedge i_clk); #1;
      end
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      exp_q.delete();
      check_reset_outputs("midrst");

      // Frame longer than the RAM keeps wrapping at one beat per cycle.
      clear_obs();
      start_frame(4990, 5005);
      wait_idle("long", 6000);
      chk("long_count", 32'(got_q.size()), 5005);
      chk("long_done_at", 32'(done_cyc - start_cyc), 5007);

      // Random frames with random backpressure and occasional abort.
      for (int f = 0; f < 40; f++) begin
         random_frame(int'($urandom_range(0, 5100)), int'($urandom_range(0, 12)),
                      ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of RAM and stream.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, width of RAM address, base_addr and length.
REQ-003 SHALL have parameter RAM_DEPTH, default 5000, number of valid RAM words (addresses 0..RAM_DEPTH-1).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a frame read; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  first RAM address of frame, sampled with start.
REQ-008 length  input  ADDR_WIDTH  number of words in frame, sampled with start.
REQ-009 abort  input  1  terminate current frame.
REQ-010 ram_addr  output  ADDR_WIDTH  read address to the combinational read port of DualPortRam.
REQ-011 ram_oe  output  1  read enable to that port, high in STREAM only.
REQ-012 ram_data  input  DATA_WIDTH  combinational read data returned for ram_addr in the same cycle.
REQ-013 m_data  output  DATA_WIDTH  stream data, registered.
REQ-014 m_valid  output  1  stream beat valid, registered.
REQ-015 m_ready  input  1  downstream accepts beat when m_valid and m_ready are high at a rising edge.
REQ-016 m_last  output  1  marks final beat of frame, qualified by m_valid.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse at frame end (normal, empty, rejected or aborted).

Function
REQ-019 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-020 IDLE + start with length!=0 and base_addr<RAM_DEPTH -> STREAM; rd_addr<=base_addr, remaining<=length.
REQ-021 IDLE + start with length==0 or base_addr>=RAM_DEPTH -> DONE; no beats produced.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 ram_addr SHALL equal rd_addr combinationally.
REQ-024 In STREAM, load condition = (!m_valid || m_ready) && remaining!=0; on load: m_data<=ram_data, m_valid<=1, m_last<=(remaining==1), rd_addr advances, remaining decrements.
REQ-025 rd_addr advance SHALL wrap RAM_DEPTH-1 -> 0.
REQ-026 STREAM -> DRAIN on the load with remaining==1.
REQ-027 Accept without load SHALL clear m_valid; m_data/m_last hold value while m_valid && !m_ready.
REQ-028 DRAIN -> DONE when final beat accepted; m_valid and m_last cleared same edge.
REQ-029 DONE -> IDLE unconditionally after one cycle; done high only in DONE.
REQ-030 Latency: start at edge N -> first m_valid at edge N+2; sustained throughput 1 beat/cycle with m_ready held high.
REQ-031 abort in STREAM or DRAIN SHALL clear m_valid/m_last next edge and go DONE; unaccepted beat discarded; abort wins over simultaneous load; abort in IDLE/DONE ignored.
REQ-032 length>RAM_DEPTH SHALL be legal; reads continue wrapping.

Reset
REQ-033 rst high at an edge SHALL force IDLE, m_valid=0, m_last=0, done=0, busy=0, ram_oe=0, m_data=0, rd_addr=0, remaining=0, in any state including mid-frame.
REQ-034 rst SHALL take priority over start and abort.

Structure
REQ-035 State encoding and default DATA_WIDTH/ADDR_WIDTH/RAM_DEPTH SHALL live in shared package fifo_pkg, reused by other fifo blocks.
REQ-036 No sub-module; DualPortRam instantiated by parent or bench; RTL 120-400 lines.

Verification
REQ-037 Bench SHALL preload DualPortRam mem[a]=a[7:0] via write port.
REQ-038 base=10,len=4,m_ready=1 -> beats 0x0A,0x0B,0x0C,0x0D; first m_valid 2 cycles after start; m_last on 0x0D; done 1 cycle after.
REQ-039 base=4998,len=4 -> addresses 4998,4999,0,1; data 0x86,0x87,0x00,0x01.
REQ-040 base=20,len=3,m_ready low 5 cycles after first valid -> m_data=0x14 held stable; then 0x15,0x16, no loss/duplication.
REQ-041 len=0 or base=5000 -> no m_valid, done 1 cycle after start; start during busy ignored.
REQ-042 base=100,len=50, abort after 3rd accept -> m_valid low next cycle, done pulse; rst mid-frame -> all outputs at reset values next cycle.
